mvm_axis_injector: RTL and testbench
====================================

# mvm_axis_injector

Synthesizable AXI-stream packet injector that replaces the behavioural weight/instruction/input sequencing loops used to drive `mvm_top`. A host-side command plus data stream is turned into NoC flits. Each flit carries the `TUSER` encoding the MVM tiles expect: RF address, op code and one-hot lane select. The block keeps a per-destination RF write pointer, so repeated weight loads to the same tile continue where the last one stopped. It sits between the host/DMA port and `mvm_top` `AXIS_S_*`, and optionally measures compute latency from the first input flit to the first result.

## Interface
- `DATAW`, 512, flit data width
- `DESTW`, 12, NoC destination width
- `ADDRW`, 9, RF address width
- `LANES`, 64, lanes per RF row; `USERW` = `ADDRW`+2+`LANES`
- `NUM_DEST`, 4, number of MVM tiles; legal destinations 1..`NUM_DEST`
- `LENW`, 16, command length width
- `CNTW`, 32, cycle counter width

Ports:
- `CLK` in 1: single clock
- `RST` in 1: asynchronous, active-high reset
- `CMD_VALID` in 1, `CMD_READY` out 1: command handshake
- `CMD_OP` in 2: 2'b11 weight, 2'b00 instruction, 2'b10 input, 2'b01 reserved
- `CMD_DEST` in `DESTW`: target tile
- `CMD_LEN` in `LENW`: number of data words that follow
- `DIN_VALID` in 1, `DIN_READY` out 1, `DIN_DATA` in `DATAW`: payload stream
- `M_TVALID` out 1, `M_TREADY` in 1, `M_TDATA` out `DATAW`, `M_TUSER` out `USERW`, `M_TDEST` out `DESTW`, `M_TLAST` out 1: NoC master
- `RES_VALID` in 1: NoC result-valid observation (`AXIS_M_TVALID`)
- `CNT_CLR` in 1: clear and arm the cycle counter
- `CYCLES` out `CNTW`, `DONE` out 1: measured latency; `DONE` means the measurement is complete
- `ERR` out 1: sticky error for a bad destination or a reserved op

## Operation
- FSM states: IDLE, STREAM, FLUSH.
- IDLE:
  - `CMD_READY`=1.
  - On a command handshake, the command is latched.
  - Bad command (`CMD_DEST`=0, `CMD_DEST`>`NUM_DEST`, or op 2'b01): set `ERR`, drop the command, stay in IDLE.
  - `CMD_LEN`=0: accepted with no flits and no pointer change; stay in IDLE.
  - Otherwise go to STREAM with remaining = `CMD_LEN`.
- STREAM: each accepted `DIN` word produces one flit.
  - `M_TDATA` = `DIN_DATA`, `M_TDEST` = latched destination, `M_TLAST`=1 on every flit.
- Weight flits (op 11):
  - `TUSER[ADDRW-1:0]` = `rfptr[dest]`, `TUSER[ADDRW+1:ADDRW]` = 2'b11.
  - `TUSER[ADDRW+2+lane]`=1; all other lane bits are 0.
  - `lane` increments per flit. After the flit with `lane`=`LANES`-1: `lane`←0 and `rfptr[dest]`+1.
- Instruction flits (op 00): `TUSER`=0.
- Input flits (op 10): `TUSER` op field = 2'b10, all other `TUSER` bits 0.
- End of command:
  - When the last word is accepted: if weight op with `lane`≠0 (partial row), go to FLUSH; otherwise go to IDLE.
  - FLUSH (1 cycle): `rfptr[dest]`+1, `lane`←0, then IDLE.
- RF pointers:
  - `rfptr[1..NUM_DEST]` reset to 0 and persist across commands.
  - Increment wraps modulo 2^`ADDRW`.
- Cycle counter:
  - `CNT_CLR` sets count=0, `DONE`=0, armed=1.
  - Armed: the first accepted input-op flit on M clears armed and sets running.
  - Running: count +1 every cycle. On `RES_VALID`=1: stop, `DONE`=1.
  - `CNT_CLR` together with `RES_VALID` in the same cycle: clear wins.

## Timing
- Reset values:
  - `CMD_READY`=0 during reset, 1 in the first cycle after.
  - `DIN_READY`=0, `M_TVALID`=0, `M_TDATA`/`M_TUSER`/`M_TDEST`=0, `M_TLAST`=0.
  - `CYCLES`=0, `DONE`=0, `ERR`=0; FSM=IDLE; all `rfptr`=0; `lane`=0.
- Output register: one stage. A `DIN` handshake in cycle N gives `M_TVALID` in N+1.
- `DIN_READY` = STREAM && remaining≠0 && (!`M_TVALID` || `M_TREADY`). This gives full throughput of 1 flit/cycle under constant `M_TREADY`.
- AXIS rule: once `M_TVALID`=1, the M outputs hold stable until `M_TREADY`=1.
- The return to IDLE does not wait for the last flit to drain. A new command may be accepted while the last flit is still pending.
- The counter's first counted cycle is the cycle after the starting handshake. `CYCLES` = cycles from input handshake to `RES_VALID`, inclusive of the `RES_VALID` cycle.
- `RST` mid-stream: everything returns to reset values immediately; the in-flight flit is lost.

## Configuration
- `MVM_INJ_CYCLE_COUNT_EN`:
  - Defined: counter, `CNT_CLR`, `RES_VALID` logic present as above.
  - Undefined: counter logic omitted; `CYCLES`=0 and `DONE`=0 constantly; `CNT_CLR` and `RES_VALID` ignored.

## Test plan
- Weight to dest 1, `CMD_LEN`=130, `M_TREADY`=1:
  - 130 flits; rows 0/1 carry lane bits 0..63, row 2 carries lanes 0..1.
  - Then a FLUSH cycle; `rfptr[1]`=3.
  - A second 64-word weight command to dest 1 uses RF address 3.
- Instruction to dest 2, `CMD_LEN`=4: 4 flits with `TUSER`=0, `M_TDEST`=2, `TLAST`=1 each, `rfptr` unchanged.
- Backpressure: input command `CMD_LEN`=8 with `M_TREADY` toggling 1,0,0,1,…:
  - `M_TDATA`/`M_TUSER` stable while stalled.
  - All 8 words arrive in order with op field 2'b10.
- Errors:
  - `CMD_DEST`=0, `CMD_DEST`=5, and op 2'b01: `ERR`=1, no flits emitted.
  - `CMD_LEN`=0 weight command: no flits, `rfptr` unchanged.
- Counter:
  - `CNT_CLR`, then input flit accepted at cycle 10, `RES_VALID` at cycle 47: `CYCLES`=37, `DONE`=1.
  - A later `RES_VALID` leaves `CYCLES` unchanged.
  - With the macro undefined: `CYCLES`=0, `DONE`=0.
- Reset mid-weight stream (after 20 of 64 words): all outputs return to reset values and `rfptr[dest]`=0.

Source files
------------

// File: rtl/mvm_axis_injector.sv
// mvm_axis_injector
// Turns a host command + payload stream into NoC flits for mvm_top, tagging
// each flit with the TUSER layout the MVM tiles decode:
//   TUSER = {lane one-hot [LANES], op [2], RF address [ADDRW]}
// Keeps a per-destination RF write pointer so consecutive weight loads to
// the same tile append rather than overwrite.
// Optional feature macro: MVM_INJ_CYCLE_COUNT_EN adds a latency counter
// measuring from the first input flit leaving on M to the first RES_VALID.
module mvm_axis_injector #(
    parameter int DATAW    = 512,
    parameter int DESTW    = 12,
    parameter int ADDRW    = 9,
    parameter int LANES    = 64,
    parameter int NUM_DEST = 4,
    parameter int LENW     = 16,
    parameter int CNTW     = 32,
    localparam int USERW   = ADDRW + 2 + LANES
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [DESTW-1:0] CMD_DEST,
    input  logic [LENW-1:0]  CMD_LEN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic [DATAW-1:0] DIN_DATA,
    output logic             M_TVALID,
    input  logic             M_TREADY,
    output logic [DATAW-1:0] M_TDATA,
    output logic [USERW-1:0] M_TUSER,
    output logic [DESTW-1:0] M_TDEST,
    output logic             M_TLAST,
    input  logic             RES_VALID,
    input  logic             CNT_CLR,
    output logic [CNTW-1:0]  CYCLES,
    output logic             DONE,
    output logic             ERR
);

    localparam int LANEW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DIDXW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam logic [DESTW-1:0] MAX_DEST  = DESTW'(NUM_DEST);
    localparam logic [LANEW-1:0] LAST_LANE = LANEW'(LANES - 1);

    localparam logic [1:0] OP_WEIGHT = 2'b11;
    localparam logic [1:0] OP_INSTR  = 2'b00;
    localparam logic [1:0] OP_INPUT  = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       op_q;
    logic [DESTW-1:0] dest_q;
    logic [LENW-1:0]  rem_q;
    logic [LANEW-1:0] lane_q;
    logic [ADDRW-1:0] rfptr_q [NUM_DEST];
    logic             ready_en_q;
    logic             err_q;

    logic             m_tvalid_q;
    logic [DATAW-1:0] m_tdata_q;
    logic [USERW-1:0] m_tuser_q;
    logic [DESTW-1:0] m_tdest_q;
    logic             m_tlast_q;

    logic             cmd_hs;
    logic             cmd_bad;
    logic             din_hs;
    logic             last_word;
    logic             op_weight;
    logic             lane_wrap;
    logic [LANEW-1:0] lane_nxt;
    logic [DIDXW-1:0] dest_idx;
    logic [ADDRW-1:0] cur_ptr;
    logic [USERW-1:0] flit_user;

    assign cmd_hs    = CMD_VALID && CMD_READY;
    assign cmd_bad   = (CMD_DEST == '0) || (CMD_DEST > MAX_DEST) || (CMD_OP == OP_RSVD);
    assign din_hs    = DIN_VALID && DIN_READY;
    assign last_word = din_hs && (rem_q == LENW'(1));
    assign op_weight = (op_q == OP_WEIGHT);
    assign lane_wrap = (lane_q == LAST_LANE);
    assign lane_nxt  = lane_wrap ? '0 : lane_q + 1'b1;
    assign dest_idx  = DIDXW'(dest_q - 1'b1);
    assign cur_ptr   = rfptr_q[dest_idx];

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state: partial weight rows take one extra cycle to close the row
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_hs && !cmd_bad && (CMD_LEN != '0)) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (last_word) begin
                    if (op_weight && (lane_nxt != '0)) state_nxt = S_FLUSH;
                    else                                state_nxt = S_IDLE;
                end
            end
            S_FLUSH:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: payload is only pulled when the output stage can take it
    always_comb begin
        CMD_READY = ready_en_q && (state == S_IDLE);
        DIN_READY = (state == S_STREAM) && (rem_q != '0) && (!m_tvalid_q || M_TREADY);
    end

    // Holds CMD_READY low while in reset; rises on the first edge afterwards
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ready_en_q <= 1'b0;
        else     ready_en_q <= 1'b1;
    end

    // Command latch and remaining-word count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q   <= OP_INSTR;
            dest_q <= '0;
            rem_q  <= '0;
        end else if (cmd_hs && !cmd_bad) begin
            op_q   <= CMD_OP;
            dest_q <= CMD_DEST;
            rem_q  <= CMD_LEN;
        end else if (din_hs) begin
            rem_q  <= rem_q - 1'b1;
        end
    end

    // Sticky error for dropped commands
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                    err_q <= 1'b0;
        else if (cmd_hs && cmd_bad) err_q <= 1'b1;
    end

    // Lane position and per-destination RF write pointers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lane_q <= '0;
            for (int unsigned i = 0; i < NUM_DEST; i++) rfptr_q[i] <= '0;
        end else if (din_hs && op_weight) begin
            lane_q <= lane_nxt;
            if (lane_wrap) rfptr_q[dest_idx] <= cur_ptr + 1'b1;
        end else if (state == S_FLUSH) begin
            lane_q <= '0;
            rfptr_q[dest_idx] <= cur_ptr + 1'b1;
        end
    end

    // TUSER for the flit being accepted from DIN
    always_comb begin
        flit_user = '0;
        case (op_q)
            OP_WEIGHT: begin
                flit_user[ADDRW-1:0]       = cur_ptr;
                flit_user[ADDRW+1:ADDRW]   = OP_WEIGHT;
                flit_user[USERW-1:ADDRW+2] = LANES'(1) << lane_q;
            end
            OP_INPUT:  flit_user[ADDRW+1:ADDRW] = OP_INPUT;
            default:   flit_user = '0;
        endcase
    end

    // Single output register stage; DIN_READY guarantees a held flit is never overwritten
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= '0;
            m_tdest_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else if (din_hs) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= DIN_DATA;
            m_tuser_q  <= flit_user;
            m_tdest_q  <= dest_q;
            m_tlast_q  <= 1'b1;
        end else if (M_TREADY) begin
            m_tvalid_q <= 1'b0;
        end
    end

    assign M_TVALID = m_tvalid_q;
    assign M_TDATA  = m_tdata_q;
    assign M_TUSER  = m_tuser_q;
    assign M_TDEST  = m_tdest_q;
    assign M_TLAST  = m_tlast_q;
    assign ERR      = err_q;

`ifdef MVM_INJ_CYCLE_COUNT_EN
    logic            armed_q;
    logic            running_q;
    logic            done_q;
    logic [CNTW-1:0] cnt_q;
    logic            start;

    assign start = armed_q && M_TVALID && M_TREADY && (M_TUSER[ADDRW+1:ADDRW] == OP_INPUT);

    // Latency counter: clear arms, first input flit on M starts, RES_VALID stops
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            armed_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else if (CNT_CLR) begin
            armed_q   <= 1'b1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (start) begin
                armed_q   <= 1'b0;
                running_q <= 1'b1;
            end
            if (running_q) begin
                cnt_q <= cnt_q + 1'b1;
                if (RES_VALID) begin
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
            end
        end
    end

    assign CYCLES = cnt_q;
    assign DONE   = done_q;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = CNT_CLR ^ RES_VALID;
    assign CYCLES = '0;
    assign DONE   = 1'b0;
`endif

endmodule

// File: tb/tb_mvm_axis_injector.sv
// Self-checking bench for mvm_axis_injector. A reference model computes the
// expected flit sequence per command from the row/lane arithmetic
// (word i of a weight load lands at row ptr + i/LANES, lane i%LANES).
module tb_mvm_axis_injector;

    localparam int DATAW    = 512;
    localparam int DESTW    = 12;
    localparam int ADDRW    = 9;
    localparam int LANES    = 64;
    localparam int NUM_DEST = 4;
    localparam int LENW     = 16;
    localparam int CNTW     = 32;
    localparam int USERW    = ADDRW + 2 + LANES;

    logic             CLK;
    logic             RST;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [DESTW-1:0] CMD_DEST;
    logic [LENW-1:0]  CMD_LEN;
    logic             DIN_VALID;
    logic             DIN_READY;
    logic [DATAW-1:0] DIN_DATA;
    logic             M_TVALID;
    logic             M_TREADY;
    logic [DATAW-1:0] M_TDATA;
    logic [USERW-1:0] M_TUSER;
    logic [DESTW-1:0] M_TDEST;
    logic             M_TLAST;
    logic             RES_VALID;
    logic             CNT_CLR;
    logic [CNTW-1:0]  CYCLES;
    logic             DONE;
    logic             ERR;

    mvm_axis_injector #(
        .DATAW(DATAW), .DESTW(DESTW), .ADDRW(ADDRW), .LANES(LANES),
        .NUM_DEST(NUM_DEST), .LENW(LENW), .CNTW(CNTW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_DEST(CMD_DEST), .CMD_LEN(CMD_LEN),
        .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY), .DIN_DATA(DIN_DATA),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA),
        .M_TUSER(M_TUSER), .M_TDEST(M_TDEST), .M_TLAST(M_TLAST),
        .RES_VALID(RES_VALID), .CNT_CLR(CNT_CLR),
        .CYCLES(CYCLES), .DONE(DONE), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [USERW-1:0] user;
        logic [DESTW-1:0] dest;
        logic             last;
    } flit_t;

    flit_t            obs_q[$];
    flit_t            exp_q[$];
    logic [DATAW-1:0] words[$];
    logic [ADDRW-1:0] mdl_ptr [1:NUM_DEST];
    int               checks = 0;
    int               failures = 0;
    int               stall_viol = 0;
    int               stall_cycles = 0;
    flit_t            prev;
    logic             prev_stall = 1'b0;

    // Capture every accepted flit and watch for output changes during stalls
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_cycles++;
                if (M_TVALID !== 1'b1 || M_TDATA !== prev.data || M_TUSER !== prev.user ||
                    M_TDEST !== prev.dest)
                    stall_viol++;
            end
            if (M_TVALID && M_TREADY) obs_q.push_back('{M_TDATA, M_TUSER, M_TDEST, M_TLAST});
            prev_stall = M_TVALID && !M_TREADY;
            prev = '{M_TDATA, M_TUSER, M_TDEST, M_TLAST};
        end
    end

    function automatic logic [DATAW-1:0] rand_word();
        logic [DATAW-1:0] w;
        for (int k = 0; k < DATAW / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [USERW-1:0] mk_user(input logic [1:0] op, input logic [ADDRW-1:0] addr,
                                                 input int lane);
        logic [USERW-1:0] u;
        u = '0;
        if (op == 2'b11)
            u = (USERW'(1) << (ADDRW + 2 + lane)) | (USERW'(2'b11) << ADDRW) | USERW'(addr);
        else if (op == 2'b10)
            u = USERW'(2'b10) << ADDRW;
        return u;
    endfunction

    // Build payload and expected flits for one command; advance the model pointer
    task automatic stage(input logic [1:0] op, input int dest, input int len);
        words.delete();
        for (int i = 0; i < len; i++) begin
            words.push_back(rand_word());
            if (op == 2'b11)
                exp_q.push_back('{words[i], mk_user(op, mdl_ptr[dest] + ADDRW'(i / LANES), i % LANES),
                                  DESTW'(dest), 1'b1});
            else
                exp_q.push_back('{words[i], mk_user(op, '0, 0), DESTW'(dest), 1'b1});
        end
        if (op == 2'b11) mdl_ptr[dest] = mdl_ptr[dest] + ADDRW'((len + LANES - 1) / LANES);
    endtask

    task automatic send_cmd(input logic [1:0] op, input int dest, input int len);
        int n = 0;
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_OP = op; CMD_DEST = DESTW'(dest); CMD_LEN = LENW'(len);
        while (!CMD_READY && n < 200) begin @(negedge CLK); n++; end
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic feed(input int nwords);
        int i = 0;
        int t = 0;
        @(negedge CLK);
        while (i < nwords && t < 3000) begin
            DIN_VALID = 1'b1;
            DIN_DATA  = words[i];
            if (DIN_READY) i++;
            @(negedge CLK);
            t++;
        end
        DIN_VALID = 1'b0;
    endtask

    task automatic toggler(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge CLK); #2;
            M_TREADY = (k % 3 == 0);
        end
        @(posedge CLK); #2;
        M_TREADY = 1'b1;
    endtask

    task automatic wait_obs(input int n);
        int t = 0;
        while (obs_q.size() < n && t < 3000) begin @(negedge CLK); t++; end
        repeat (6) @(negedge CLK);
    endtask

    task automatic pulse_reset();
        @(negedge CLK); RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int d = 1; d <= NUM_DEST; d++) mdl_ptr[d] = '0;
        @(negedge CLK);
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        RST = 1'b1; CMD_VALID = 0; CMD_OP = 0; CMD_DEST = 0; CMD_LEN = 0;
        DIN_VALID = 0; DIN_DATA = '0; M_TREADY = 1; RES_VALID = 0; CNT_CLR = 0;
        for (int d = 1; d <= NUM_DEST; d++) mdl_ptr[d] = '0;
        repeat (3) @(negedge CLK);
        checks++; if (CMD_READY !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=0", CMD_READY); end
        checks++; if (DIN_READY !== 1'b0) begin failures++; $display("FAIL reset_din_ready got=%b exp=0", DIN_READY); end
        checks++; if (M_TVALID !== 1'b0 || M_TLAST !== 1'b0) begin failures++; $display("FAIL reset_m_valid_last got=%b%b exp=00", M_TVALID, M_TLAST); end
        checks++; if (M_TDATA !== '0 || M_TUSER !== '0 || M_TDEST !== '0) begin failures++; $display("FAIL reset_m_fields user=%h dest=%h exp 0", M_TUSER, M_TDEST); end
        checks++; if (CYCLES !== '0 || DONE !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL reset_status cycles=%0d done=%b err=%b exp 0", CYCLES, DONE, ERR); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (CMD_READY !== 1'b1) begin failures++; $display("FAIL post_reset_cmd_ready got=%b exp=1", CMD_READY); end
        obs_q.delete();
    endtask

    task automatic test_weight();
        flit_t o, e;
        stage(2'b11, 1, 130);
        send_cmd(2'b11, 1, 130);
        feed(130);
        wait_obs(130);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL weight_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL weight_flit user=%h dest=%h last=%b exp user=%h dest=%h data_ok=%b", o.user, o.dest, o.last, e.user, e.dest, o.data === e.data); end
        end
        obs_q.delete(); exp_q.delete();
        stage(2'b11, 1, 64);
        send_cmd(2'b11, 1, 64);
        feed(64);
        wait_obs(64);
        checks++; if (obs_q.size() != 64) begin failures++; $display("FAIL weight2_count got=%0d exp=64", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0].user[ADDRW-1:0] !== ADDRW'(3)) begin failures++; $display("FAIL weight2_addr got=%0d exp=3", obs_q[0].user[ADDRW-1:0]); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL weight2_flit user=%h exp user=%h data_ok=%b", o.user, e.user, o.data === e.data); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_instr();
        flit_t o, e;
        stage(2'b00, 2, 4);
        send_cmd(2'b00, 2, 4);
        feed(4);
        stage(2'b11, 2, 2);
        send_cmd(2'b11, 2, 2);
        feed(2);
        wait_obs(6);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL instr_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL instr_flit user=%h dest=%h last=%b exp user=%h dest=%h data_ok=%b", o.user, o.dest, o.last, e.user, e.dest, o.data === e.data); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        flit_t o, e;
        stall_viol = 0; stall_cycles = 0;
        stage(2'b10, 3, 8);
        send_cmd(2'b10, 3, 8);
        fork
            feed(8);
            toggler(60);
        join
        wait_obs(8);
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stable violations=%0d exp=0", stall_viol); end
        checks++; if (stall_cycles == 0) begin failures++; $display("FAIL bp_stalls_seen got=0 exp>0"); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL bp_flit user=%h dest=%h exp user=%h dest=%h data_ok=%b", o.user, o.dest, e.user, e.dest, o.data === e.data); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_len0();
        flit_t o, e;
        send_cmd(2'b11, 3, 0);
        repeat (8) @(negedge CLK);
        checks++; if (obs_q.size() != 0 || DIN_READY !== 1'b0) begin failures++; $display("FAIL len0_no_flits got=%0d din_ready=%b exp 0", obs_q.size(), DIN_READY); end
        stage(2'b11, 3, 5);
        send_cmd(2'b11, 3, 5);
        feed(5);
        wait_obs(5);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL len0_follow_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL len0_follow_flit user=%h exp user=%h data_ok=%b", o.user, e.user, o.data === e.data); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_counter();
        int k_list[2];
        int t;
        k_list[0] = 37;
        k_list[1] = $urandom_range(3, 80);
        for (int r = 0; r < 2; r++) begin
            @(negedge CLK); CNT_CLR = 1'b1;
            @(posedge CLK); #1; CNT_CLR = 1'b0;
            @(negedge CLK);
            checks++; if (CYCLES !== '0 || DONE !== 1'b0) begin failures++; $display("FAIL cnt_clear cycles=%0d done=%b exp 0/0", CYCLES, DONE); end
            // RES_VALID while only armed must not complete a measurement
            RES_VALID = 1'b1; @(posedge CLK); #1; RES_VALID = 1'b0;
            @(negedge CLK);
            checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL cnt_armed_res done=%b exp=0", DONE); end
            stage(2'b10, 2, 1);
            send_cmd(2'b10, 2, 1);
            fork
                feed(1);
                begin
                    t = 0;
                    while (!(M_TVALID && M_TREADY) && t < 200) begin @(negedge CLK); t++; end
                    repeat (k_list[r]) @(posedge CLK);
                    @(negedge CLK); RES_VALID = 1'b1;
                    @(posedge CLK); #1; RES_VALID = 1'b0;
                end
            join
            @(negedge CLK);
`ifdef MVM_INJ_CYCLE_COUNT_EN
            checks++; if (t >= 200 || CYCLES !== CNTW'(k_list[r]) || DONE !== 1'b1) begin failures++; $display("FAIL cnt_measure cycles=%0d done=%b exp %0d/1", CYCLES, DONE, k_list[r]); end
            repeat (5) @(negedge CLK);
            RES_VALID = 1'b1; @(posedge CLK); #1; RES_VALID = 1'b0;
            @(negedge CLK);
            checks++; if (CYCLES !== CNTW'(k_list[r]) || DONE !== 1'b1) begin failures++; $display("FAIL cnt_hold cycles=%0d done=%b exp %0d/1", CYCLES, DONE, k_list[r]); end
            @(negedge CLK); CNT_CLR = 1'b1; RES_VALID = 1'b1;
            @(posedge CLK); #1; CNT_CLR = 1'b0; RES_VALID = 1'b0;
            @(negedge CLK);
            checks++; if (CYCLES !== '0 || DONE !== 1'b0) begin failures++; $display("FAIL cnt_clear_wins cycles=%0d done=%b exp 0/0", CYCLES, DONE); end
`else
            checks++; if (CYCLES !== '0 || DONE !== 1'b0) begin failures++; $display("FAIL cnt_disabled cycles=%0d done=%b exp 0/0", CYCLES, DONE); end
`endif
            wait_obs(1);
            checks++; if (obs_q.size() != 1 || (obs_q.size() == 1 && obs_q[0] !== exp_q[0])) begin failures++; $display("FAIL cnt_flit count=%0d exp=1 or content differs", obs_q.size()); end
            obs_q.delete(); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        flit_t o, e;
        words.delete();
        for (int i = 0; i < 20; i++) words.push_back(rand_word());
        send_cmd(2'b11, 1, 64);
        feed(20);
        RST = 1'b1;
        #1;
        checks++; if (CMD_READY !== 1'b0 || DIN_READY !== 1'b0) begin failures++; $display("FAIL rstmid_ready cmd=%b din=%b exp 0/0", CMD_READY, DIN_READY); end
        checks++; if (M_TVALID !== 1'b0 || M_TLAST !== 1'b0 || M_TDATA !== '0 || M_TUSER !== '0 || M_TDEST !== '0) begin failures++; $display("FAIL rstmid_m valid=%b last=%b user=%h dest=%h exp 0", M_TVALID, M_TLAST, M_TUSER, M_TDEST); end
        checks++; if (CYCLES !== '0 || DONE !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL rstmid_status cycles=%0d done=%b err=%b exp 0", CYCLES, DONE, ERR); end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int d = 1; d <= NUM_DEST; d++) mdl_ptr[d] = '0;
        @(negedge CLK);
        obs_q.delete(); exp_q.delete();
        stage(2'b11, 1, 3);
        send_cmd(2'b11, 1, 3);
        feed(3);
        wait_obs(3);
        checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL rstmid_count got=%0d exp=3", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0].user[ADDRW-1:0] !== '0) begin failures++; $display("FAIL rstmid_rfptr got=%0d exp=0", obs_q[0].user[ADDRW-1:0]); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin failures++; $display("FAIL rstmid_flit user=%h exp user=%h data_ok=%b", o.user, e.user, o.data === e.data); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_errors();
        logic [1:0] bad_op[3];
        int         bad_dest[3];
        bad_op[0] = 2'b11; bad_dest[0] = 0;
        bad_op[1] = 2'b00; bad_dest[1] = 5;
        bad_op[2] = 2'b01; bad_dest[2] = 1;
        for (int b = 0; b < 3; b++) begin
            pulse_reset();
            checks++; if (ERR !== 1'b0) begin failures++; $display("FAIL err_pre[%0d] got=%b exp=0", b, ERR); end
            send_cmd(bad_op[b], bad_dest[b], 4);
            @(negedge CLK);
            DIN_VALID = 1'b1; DIN_DATA = rand_word();
            repeat (6) @(negedge CLK);
            checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL err_set[%0d] got=%b exp=1", b, ERR); end
            checks++; if (obs_q.size() != 0 || DIN_READY !== 1'b0 || CMD_READY !== 1'b1) begin failures++; $display("FAIL err_dropped[%0d] flits=%0d din_ready=%b cmd_ready=%b exp 0/0/1", b, obs_q.size(), DIN_READY, CMD_READY); end
            DIN_VALID = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_weight();
        test_instr();
        test_backpressure();
        test_len0();
        test_counter();
        test_reset_mid();
        test_errors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
